// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared constants and encodings for the multiply/divide unit
package multdiv_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic {
        OP_MULT,
        OP_DIV
    } op_t;

endpackage

// File: rtl/alu_multdiv_unit_if.sv
// rtl/alu_multdiv_unit_if.sv - operand/control/result bundle of the multiply/divide unit
interface alu_multdiv_unit_if;
    import multdiv_pkg::*;

    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY
    );

endinterface

// File: rtl/div_restoring_core.sv
// rtl/div_restoring_core.sv - unsigned restoring divider, one shift/subtract step per enable
module div_restoring_core (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        en,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient_next
);

    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic [32:0] partial;
    logic        fits;
    logic [31:0] rem_next;

    // Shift the next dividend bit into the remainder and subtract when the divisor fits;
    // the partial remainder needs 33 bits because it can reach 2*divisor-1 before the subtract.
    always_comb begin
        partial       = {rem, quo[31]};
        fits          = partial >= {1'b0, dvs};
        rem_next      = fits ? 32'(partial - {1'b0, dvs}) : partial[31:0];
        quotient_next = {quo[30:0], fits};
    end

    // Load magnitudes on start; otherwise advance one step per enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            rem <= '0;
            quo <= '0;
            dvs <= '0;
        end else if (load) begin
            rem <= '0;
            quo <= dividend;
            dvs <= divisor;
        end else if (en) begin
            rem <= rem_next;
            quo <= quotient_next;
        end
    end

endmodule

// File: rtl/alu_multdiv_unit.sv
// rtl/alu_multdiv_unit.sv - iterative signed 32-bit Booth multiply / restoring divide (divider under MULTDIV_DIV_EN)
module alu_multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = multdiv_pkg::WIDTH,
    parameter int ITER  = multdiv_pkg::ITER
) (
    input  logic                clock,
    input  logic                reset,
    alu_multdiv_unit_if.slave   bus
);

    state_t           state;
    op_t              op;
    logic [4:0]       count;
    logic [WIDTH-1:0] mcand;
    logic [64:0]      booth;
    logic [64:0]      booth_next;
    logic [32:0]      acc;
    logic [32:0]      sum;
    logic [63:0]      product;
    logic             mult_exc;
    logic             start;
    logic             last;
    logic [31:0]      fin_result;
    logic             fin_exc;
    logic [31:0]      result_q;
    logic             exc_q;
    logic             rdy_q;

    assign start = bus.ctrl_MULT | bus.ctrl_DIV;
    assign last  = (state == RUN) && (count == 5'(ITER - 1));

    // One Booth step: add/subtract the multiplicand per {lo[0], q-1}, then arithmetic shift right.
    // The accumulator is 33 bits so subtracting INT_MIN cannot wrap.
    always_comb begin
        acc = {booth[64], booth[64:33]};
        unique case (booth[1:0])
            2'b01:   sum = acc + {mcand[31], mcand};
            2'b10:   sum = acc - {mcand[31], mcand};
            default: sum = acc;
        endcase
        booth_next = {sum, booth[32:1]};
        product    = booth_next[64:1];
        mult_exc   = !((&product[63:31]) || !(|product[63:31]));
    end

`ifdef MULTDIV_DIV_EN
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] quotient_next;
    logic        div_neg;
    logic        div_zero;
    logic        div_ovf;

    assign abs_a = bus.data_operandA[31] ? -bus.data_operandA : bus.data_operandA;
    assign abs_b = bus.data_operandB[31] ? -bus.data_operandB : bus.data_operandB;

    div_restoring_core u_div (
        .clock         (clock),
        .reset         (reset),
        .load          (bus.ctrl_DIV && !bus.ctrl_MULT),
        .en            (state == RUN && op == OP_DIV),
        .dividend      (abs_a),
        .divisor       (abs_b),
        .quotient_next (quotient_next)
    );

    // Special-case flags are captured with the operands; the core only sees magnitudes.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_neg  <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
        end else if (start) begin
            div_neg  <= bus.data_operandA[31] ^ bus.data_operandB[31];
            div_zero <= bus.data_operandB == '0;
            div_ovf  <= (bus.data_operandA == INT_MIN) && (bus.data_operandB == '1);
        end
    end
`endif

    // Select the value latched on entry to DONE, applying divide sign and exception rules.
    always_comb begin
        fin_result = product[31:0];
        fin_exc    = mult_exc;
        if (op == OP_DIV) begin
`ifdef MULTDIV_DIV_EN
            if (div_zero) begin
                fin_result = '0;
                fin_exc    = 1'b1;
            end else if (div_ovf) begin
                fin_result = INT_MIN;
                fin_exc    = 1'b1;
            end else begin
                fin_result = div_neg ? -quotient_next : quotient_next;
                fin_exc    = 1'b0;
            end
`else
            fin_result = '0;
            fin_exc    = 1'b1;
`endif
        end
    end

    // Control FSM: a start in any state restarts; results update only when entering DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            op       <= OP_MULT;
            count    <= '0;
            mcand    <= '0;
            booth    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            if (start) begin
                state <= RUN;
                op    <= bus.ctrl_MULT ? OP_MULT : OP_DIV;
                count <= '0;
                mcand <= bus.data_operandA;
                booth <= {32'b0, bus.data_operandB, 1'b0};
            end else begin
                unique case (state)
                    RUN: begin
                        booth <= booth_next;
                        if (last) begin
                            state    <= DONE;
                            count    <= '0;
                            result_q <= fin_result;
                            exc_q    <= fin_exc;
                            rdy_q    <= 1'b1;
                        end else begin
                            count <= count + 5'd1;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;

endmodule
